// File: rtl/clock_phase_pkg.sv
// clock_phase_pkg: shared phase/state encodings and strobe masks for the clock sequencer
package clock_phase_pkg;
   typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, MEM = 2'd2, WB = 2'd3} phase_e;
   typedef enum logic [2:0] {S_IDLE = 3'd0, S_P0 = 3'd1, S_P1 = 3'd2, S_P2 = 3'd3, S_P3 = 3'd4} state_e;
   localparam int NUM_PHASES = 4;
   // strobe masks ordered {processor, imem, dmem, regfile}
   localparam logic [3:0] MASK_FETCH  = 4'b1000;
   localparam logic [3:0] MASK_DECODE = 4'b1100;
   localparam logic [3:0] MASK_MEM    = 4'b0010;
   localparam logic [3:0] MASK_WB     = 4'b0001;
   function automatic phase_e state_phase(state_e s);
      return s == S_P1 ? DECODE : s == S_P2 ? MEM : s == S_P3 ? WB : FETCH;
   endfunction
   function automatic logic [3:0] strobe_mask(state_e s);
      return s == S_P0 ? MASK_FETCH : s == S_P1 ? MASK_DECODE :
             s == S_P2 ? MASK_MEM : s == S_P3 ? MASK_WB : 4'b0000;
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: counts main cycles within a phase and flags the last one
module phase_timer
   import clock_phase_pkg::*;
#(
   parameter int PHASE_LEN = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic last
);
   localparam int W = PHASE_LEN > 1 ? $clog2(PHASE_LEN) : 1;
   logic [W-1:0] cnt;
   assign last = cnt == W'(PHASE_LEN - 1);
   // wrap at phase end; held at zero while idle so P0 always starts fresh
   always_ff @(posedge clock)
      cnt <= (reset || restart || last) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/clock_phase_gen.sv
// clock_phase_gen: four-phase registered clock sequencer with halt, single-step and cycle counter
module clock_phase_gen
   import clock_phase_pkg::*;
#(
   parameter int PHASE_LEN = 1,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             halt,
   input  logic             step,
   output logic             processor_clock,
   output logic             imem_clock,
   output logic             dmem_clock,
   output logic             regfile_clock,
   output logic [1:0]       phase,
   output logic             running,
   output logic [CNT_W-1:0] cycle_count
);
   state_e state, state_n;
   logic   step_pending, step_pending_n, last;

   phase_timer #(.PHASE_LEN(PHASE_LEN)) u_timer (
      .clock  (clock),
      .reset  (reset),
      .restart(state == S_IDLE),
      .last   (last)
   );

   // next state: halt only sampled in IDLE and at the P3->P0 boundary
   always_comb begin
      state_n = state;
      step_pending_n = step_pending;
      if (state == S_IDLE) begin
         state_n = (!halt || step) ? S_P0 : S_IDLE;
         step_pending_n = halt && step;
      end else if (last) begin
         state_n = state == S_P0 ? S_P1 : state == S_P1 ? S_P2 : state == S_P2 ? S_P3 :
                   (halt || step_pending) ? S_IDLE : S_P0;
         if (state == S_P3) step_pending_n = 1'b0;
      end
   end

   // outputs decoded from next state so every strobe is a clean register output
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         step_pending <= 1'b0;
         {processor_clock, imem_clock, dmem_clock, regfile_clock} <= 4'b0000;
         phase <= 2'd0;
         running <= 1'b0;
         cycle_count <= '0;
      end else begin
         state <= state_n;
         step_pending <= step_pending_n;
         {processor_clock, imem_clock, dmem_clock, regfile_clock} <= strobe_mask(state_n);
         phase <= state_phase(state_n);
         running <= state_n != S_IDLE;
         if (state_n == S_P0 && state != S_P0) cycle_count <= cycle_count + 1'b1;
      end
   end
endmodule
